// File: rtl/ram_port_arbiter_if.sv
// Bus bundle for ram_port_arbiter: SPI slave side, host side, RAM side and
// status flags. The arbiter connects through the slave modport; the
// environment driving requesters and the RAM model uses the master modport.
interface ram_port_arbiter_if;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic       spi_ss_n;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       host_req;
  logic [9:0] host_cmd;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       owner;
  logic       ovf_err;
  logic       tmo_err;

  modport slave (
    input  spi_rx_data, spi_rx_valid, spi_ss_n,
    input  host_req, host_cmd,
    input  ram_dout, ram_tx_valid,
    output spi_tx_data, spi_tx_valid,
    output host_gnt, host_rdata, host_rvalid,
    output ram_din, ram_rx_valid,
    output owner, ovf_err, tmo_err
  );

  modport master (
    output spi_rx_data, spi_rx_valid, spi_ss_n,
    output host_req, host_cmd,
    output ram_dout, ram_tx_valid,
    input  spi_tx_data, spi_tx_valid,
    input  host_gnt, host_rdata, host_rvalid,
    input  ram_din, ram_rx_valid,
    input  owner, ovf_err, tmo_err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter (SPI slave and host) in front of a single-port RAM.
// SPI commands land in a one-entry buffer because the SPI strobe cannot be
// stalled; the host holds its request until granted. Address commands lock
// the RAM to their requester until the matching data command, and read-data
// commands wait for the RAM reply (bounded by RD_TIMEOUT) before returning
// the byte to whoever issued the read.
module ram_port_arbiter #(
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    LOCK_SPI  = 2'd1,
    LOCK_HOST = 2'd2,
    WAIT_RD   = 2'd3
  } arb_state_t;

  // Command code [9:8] decides where the arbiter goes after issuing it.
  function automatic arb_state_t cmd_next_state(input logic [1:0] code,
                                                input logic       from_host);
    arb_state_t nxt;
    case (code)
      2'b00, 2'b10: nxt = from_host ? LOCK_HOST : LOCK_SPI;
      2'b01:        nxt = ARB_IDLE;
      2'b11:        nxt = WAIT_RD;
      default:      nxt = ARB_IDLE;
    endcase
    return nxt;
  endfunction

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             spi_pend_r;
  logic [9:0]       spi_buf_r;
  logic             last_owner_r;   // 1 = host issued last; reset favours SPI
  logic             owner_r;
  logic [9:0]       ram_din_r;
  logic             ram_rx_valid_r;
  logic [7:0]       spi_tx_data_r;
  logic             spi_tx_valid_r;
  logic [7:0]       host_rdata_r;
  logic             host_rvalid_r;
  logic             ovf_err_r;
  logic             tmo_err_r;

  logic             issue_spi_s;
  logic             issue_host_s;
  logic [9:0]       issue_cmd_s;
  logic             abort_s;
  logic             rd_done_s;
  logic             rd_tmo_s;
  logic             ovf_s;

  // Arbitration, lock handling, read wait and next-state selection.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = {CNT_W{1'b0}};
    issue_spi_s  = 1'b0;
    issue_host_s = 1'b0;
    abort_s      = 1'b0;
    rd_done_s    = 1'b0;
    rd_tmo_s     = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (spi_pend_r && bus.host_req) begin
          if (last_owner_r) begin
            issue_spi_s = 1'b1;
          end else begin
            issue_host_s = 1'b1;
          end
        end else if (spi_pend_r) begin
          issue_spi_s = 1'b1;
        end else if (bus.host_req) begin
          issue_host_s = 1'b1;
        end else begin
          issue_spi_s = 1'b0;
        end
      end
      LOCK_SPI: begin
        if (bus.spi_ss_n) begin
          abort_s = 1'b1;
        end else if (spi_pend_r) begin
          issue_spi_s = 1'b1;
        end else begin
          issue_spi_s = 1'b0;
        end
      end
      LOCK_HOST: begin
        if (bus.host_req) begin
          issue_host_s = 1'b1;
        end else begin
          issue_host_s = 1'b0;
        end
      end
      WAIT_RD: begin
        // An SPI frame abort wins over a same-cycle RAM reply so the reply is discarded.
        if (bus.spi_ss_n && !owner_r) begin
          abort_s = 1'b1;
        end else if (bus.ram_tx_valid) begin
          rd_done_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          rd_tmo_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        abort_s = 1'b0;
      end
    endcase

    issue_cmd_s = issue_host_s ? bus.host_cmd : spi_buf_r;

    if (issue_spi_s || issue_host_s) begin
      state_nxt_s = cmd_next_state(issue_cmd_s[9:8], issue_host_s);
    end else if (abort_s || rd_done_s || rd_tmo_s) begin
      state_nxt_s = ARB_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // A new SPI command is lost only if the buffer is occupied and not drained this cycle.
  assign ovf_s = bus.spi_rx_valid && spi_pend_r && !issue_spi_s && !abort_s;

  // FSM state and read-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // One-entry SPI command buffer; capture and drain in one cycle keeps it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_pend_r <= 1'b0;
      spi_buf_r  <= 10'h000;
    end else begin
      if (abort_s) begin
        spi_pend_r <= 1'b0;
      end else if (bus.spi_rx_valid && (!spi_pend_r || issue_spi_s)) begin
        spi_pend_r <= 1'b1;
        spi_buf_r  <= bus.spi_rx_data;
      end else if (issue_spi_s) begin
        spi_pend_r <= 1'b0;
      end else begin
        spi_pend_r <= spi_pend_r;
      end
    end
  end

  // Registered RAM command port and ownership tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_din_r      <= 10'h000;
      ram_rx_valid_r <= 1'b0;
      owner_r        <= 1'b0;
      last_owner_r   <= 1'b1;
    end else begin
      if (issue_spi_s || issue_host_s) begin
        ram_din_r      <= issue_cmd_s;
        ram_rx_valid_r <= 1'b1;
        owner_r        <= issue_host_s;
        last_owner_r   <= issue_host_s;
      end else begin
        ram_rx_valid_r <= 1'b0;
      end
    end
  end

  // Route RAM read data back to the requester that issued the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_tx_data_r  <= 8'h00;
      spi_tx_valid_r <= 1'b0;
      host_rdata_r   <= 8'h00;
      host_rvalid_r  <= 1'b0;
    end else begin
      spi_tx_valid_r <= 1'b0;
      host_rvalid_r  <= 1'b0;
      if (rd_done_s) begin
        if (owner_r) begin
          host_rdata_r  <= bus.ram_dout;
          host_rvalid_r <= 1'b1;
        end else begin
          spi_tx_data_r  <= bus.ram_dout;
          spi_tx_valid_r <= 1'b1;
        end
      end else begin
        spi_tx_valid_r <= 1'b0;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_r <= 1'b0;
      tmo_err_r <= 1'b0;
    end else begin
      ovf_err_r <= ovf_err_r | ovf_s;
      tmo_err_r <= tmo_err_r | rd_tmo_s;
    end
  end

  assign bus.host_gnt     = issue_host_s;
  assign bus.ram_din      = ram_din_r;
  assign bus.ram_rx_valid = ram_rx_valid_r;
  assign bus.spi_tx_data  = spi_tx_data_r;
  assign bus.spi_tx_valid = spi_tx_valid_r;
  assign bus.host_rdata   = host_rdata_r;
  assign bus.host_rvalid  = host_rvalid_r;
  assign bus.owner        = owner_r;
  assign bus.ovf_err      = ovf_err_r;
  assign bus.tmo_err      = tmo_err_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a table of per-cycle vectors covering
// writes, reads, tie-breaking, locking, overflow and SPI abort, followed by
// hand-written sequences for read timeout, abort during a read wait and
// reset in the middle of a read.
module tb_ram_port_arbiter;

  localparam logic       T  = 1'b1;
  localparam logic       F  = 1'b0;
  localparam logic [9:0] C0 = 10'h000;
  localparam logic [7:0] D0 = 8'h00;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  ram_port_arbiter_if bus ();

  ram_port_arbiter #(.RD_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       sv;
    logic [9:0] sd;
    logic       ss;
    logic       hr;
    logic [9:0] hc;
    logic       tv;
    logic [7:0] td;
    logic       e_rv;
    logic [9:0] e_din;
    logic       e_gnt;
    logic       e_stv;
    logic [7:0] e_std;
    logic       e_hrv;
    logic [7:0] e_hrd;
    logic       e_own;
    logic       e_ovf;
    logic       e_tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic sv, input logic [9:0] sd, input logic ss,
    input logic hr, input logic [9:0] hc, input logic tv, input logic [7:0] td,
    input logic erv, input logic [9:0] edin, input logic egnt,
    input logic estv, input logic [7:0] estd, input logic ehrv, input logic [7:0] ehrd,
    input logic eown, input logic eovf, input logic etmo);
    vec_t v;
    v.rst = r;  v.sv = sv; v.sd = sd; v.ss = ss; v.hr = hr; v.hc = hc; v.tv = tv; v.td = td;
    v.e_rv = erv; v.e_din = edin; v.e_gnt = egnt; v.e_stv = estv; v.e_std = estd;
    v.e_hrv = ehrv; v.e_hrd = ehrd; v.e_own = eown; v.e_ovf = eovf; v.e_tmo = etmo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic drive(input logic r, input logic sv, input logic [9:0] sd, input logic ss,
                       input logic hr, input logic [9:0] hc, input logic tv, input logic [7:0] td);
    @(posedge clk);
    #1;
    rst_n            = ~r;
    bus.spi_rx_valid = sv;
    bus.spi_rx_data  = sd;
    bus.spi_ss_n     = ss;
    bus.host_req     = hr;
    bus.host_cmd     = hc;
    bus.ram_tx_valid = tv;
    bus.ram_dout     = td;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(F, F, C0, F, F, C0, F, D0);
  endtask

  logic seen_valid;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.spi_rx_valid = 1'b0;
    bus.spi_rx_data  = 10'h000;
    bus.spi_ss_n     = 1'b0;
    bus.host_req     = 1'b0;
    bus.host_cmd     = 10'h000;
    bus.ram_tx_valid = 1'b0;
    bus.ram_dout     = 8'h00;

    //          rst sv  sd       ss hr  hc       tv td     rv  din      gnt stv std    hrv hrd    own ovf tmo
    // Reset, then SPI wr-addr 0x005 and wr-data 0x1A5 back to back
    vecs.push_back(mk(T, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, T, 10'h005, F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, T, 10'h1A5, F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    T, 10'h005, F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    T, 10'h1A5, F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    // SPI rd-addr 0x203, rd-data 0x300, RAM replies 0x5C three cycles after the command
    vecs.push_back(mk(F, T, 10'h203, F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, T, 10'h300, F, F, C0,      F, D0,    T, 10'h203, F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    T, 10'h300, F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      T, 8'h5C, F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, T, 8'h5C, F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    // Reset, then SPI and host pending together: SPI wins the first tie
    vecs.push_back(mk(T, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, T, 10'h100, F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, T, 10'h155, F, D0,    F, C0,      F, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, T, 10'h155, F, D0,    T, 10'h100, T, F, D0,    F, D0,    F, F, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    T, 10'h155, F, F, D0,    F, D0,    T, F, F));
    // Host locks with 0x210; SPI 0x007 held, 0x0AA overflows; host read 0x3F0 returns 0xA7
    vecs.push_back(mk(F, F, C0,      F, T, 10'h210, F, D0,    F, C0,      T, F, D0,    F, D0,    T, F, F));
    vecs.push_back(mk(F, T, 10'h007, F, F, C0,      F, D0,    T, 10'h210, F, F, D0,    F, D0,    T, F, F));
    vecs.push_back(mk(F, T, 10'h0AA, F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    T, F, F));
    vecs.push_back(mk(F, F, C0,      F, T, 10'h3F0, F, D0,    F, C0,      T, F, D0,    F, D0,    T, T, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    T, 10'h3F0, F, F, D0,    F, D0,    T, T, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      T, 8'hA7, F, C0,      F, F, D0,    F, D0,    T, T, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    T, 8'hA7, T, T, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    T, 10'h007, F, F, D0,    F, D0,    F, T, F));
    // Release the SPI lock, SPI 0x004 locks again, ss_n abort lets the waiting host in
    vecs.push_back(mk(F, T, 10'h101, F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, T, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, T, F));
    vecs.push_back(mk(F, T, 10'h004, F, F, C0,      F, D0,    T, 10'h101, F, F, D0,    F, D0,    F, T, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    F, T, F));
    vecs.push_back(mk(F, F, C0,      F, T, 10'h122, F, D0,    T, 10'h004, F, F, D0,    F, D0,    F, T, F));
    vecs.push_back(mk(F, F, C0,      T, T, 10'h122, F, D0,    F, C0,      F, F, D0,    F, D0,    F, T, F));
    vecs.push_back(mk(F, F, C0,      F, T, 10'h122, F, D0,    F, C0,      T, F, D0,    F, D0,    F, T, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      T, 8'h33, T, 10'h122, F, F, D0,    F, D0,    T, T, F));
    vecs.push_back(mk(F, F, C0,      F, F, C0,      F, D0,    F, C0,      F, F, D0,    F, D0,    T, T, F));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].ss,
            vecs[i].hr, vecs[i].hc, vecs[i].tv, vecs[i].td);
      chk($sformatf("row%0d ram_rx_valid", i), {15'h0, bus.ram_rx_valid}, {15'h0, vecs[i].e_rv});
      if (vecs[i].e_rv)
        chk($sformatf("row%0d ram_din", i), {6'h0, bus.ram_din}, {6'h0, vecs[i].e_din});
      chk($sformatf("row%0d host_gnt", i), {15'h0, bus.host_gnt}, {15'h0, vecs[i].e_gnt});
      chk($sformatf("row%0d spi_tx_valid", i), {15'h0, bus.spi_tx_valid}, {15'h0, vecs[i].e_stv});
      if (vecs[i].e_stv)
        chk($sformatf("row%0d spi_tx_data", i), {8'h0, bus.spi_tx_data}, {8'h0, vecs[i].e_std});
      chk($sformatf("row%0d host_rvalid", i), {15'h0, bus.host_rvalid}, {15'h0, vecs[i].e_hrv});
      if (vecs[i].e_hrv)
        chk($sformatf("row%0d host_rdata", i), {8'h0, bus.host_rdata}, {8'h0, vecs[i].e_hrd});
      chk($sformatf("row%0d owner", i), {15'h0, bus.owner}, {15'h0, vecs[i].e_own});
      chk($sformatf("row%0d ovf_err", i), {15'h0, bus.ovf_err}, {15'h0, vecs[i].e_ovf});
      chk($sformatf("row%0d tmo_err", i), {15'h0, bus.tmo_err}, {15'h0, vecs[i].e_tmo});
    end

    // Read-data with no RAM reply: tmo_err appears 15 cycles after the command.
    drive(F, T, 10'h300, F, F, C0, F, D0);
    idle();
    idle();
    chk("tmo cmd valid", {15'h0, bus.ram_rx_valid}, 16'h0001);
    chk("tmo cmd din", {6'h0, bus.ram_din}, 16'h0300);
    seen_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      idle();
      seen_valid = seen_valid | bus.spi_tx_valid | bus.host_rvalid | bus.ram_rx_valid;
    end
    chk("tmo not yet", {15'h0, bus.tmo_err}, 16'h0000);
    drive(F, F, C0, F, T, 10'h100, F, D0);
    chk("tmo set", {15'h0, bus.tmo_err}, 16'h0001);
    chk("tmo idle gnt", {15'h0, bus.host_gnt}, 16'h0001);
    seen_valid = seen_valid | bus.spi_tx_valid | bus.host_rvalid;
    idle();
    seen_valid = seen_valid | bus.spi_tx_valid | bus.host_rvalid;
    chk("tmo no strobe", {15'h0, seen_valid}, 16'h0000);
    chk("tmo host din", {6'h0, bus.ram_din}, 16'h0100);

    // SPI abort while waiting for read data discards a same-cycle RAM reply.
    drive(F, T, 10'h301, F, F, C0, F, D0);
    idle();
    drive(F, F, C0, T, F, C0, T, 8'h99);
    chk("abort rd cmd", {6'h0, bus.ram_din}, 16'h0301);
    drive(F, F, C0, F, T, 10'h1AB, F, D0);
    chk("abort no tx_valid", {15'h0, bus.spi_tx_valid}, 16'h0000);
    chk("abort idle gnt", {15'h0, bus.host_gnt}, 16'h0001);
    idle();
    chk("abort host din", {6'h0, bus.ram_din}, 16'h01AB);
    chk("abort host owner", {15'h0, bus.owner}, 16'h0001);

    // Reset in the middle of a read wait: everything clears, late reply ignored.
    drive(F, T, 10'h302, F, F, C0, F, D0);
    idle();
    drive(T, F, C0, F, F, C0, F, D0);
    chk("rst ram_rx_valid", {15'h0, bus.ram_rx_valid}, 16'h0000);
    chk("rst ram_din", {6'h0, bus.ram_din}, 16'h0000);
    chk("rst owner", {15'h0, bus.owner}, 16'h0000);
    chk("rst ovf_err", {15'h0, bus.ovf_err}, 16'h0000);
    chk("rst tmo_err", {15'h0, bus.tmo_err}, 16'h0000);
    drive(F, F, C0, F, F, C0, T, 8'h44);
    idle();
    chk("rst no spi_tx_valid", {15'h0, bus.spi_tx_valid}, 16'h0000);
    chk("rst no host_rvalid", {15'h0, bus.host_rvalid}, 16'h0000);
    chk("rst no reissue", {15'h0, bus.ram_rx_valid}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
